// File: rtl/inst_mem_resp_if.sv
// Fetch/response and boot-load signal bundle for inst_mem_resp.
// slave = the memory responder, master = the core / loader side.
interface inst_mem_resp_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  req_i;
    logic [31:0]           addr_i;
    logic [31:0]           inst_o;
    logic                  ack_o;
    logic                  err_o;
    logic                  busy_o;
    logic                  ld_we_i;
    logic [DEPTH_LOG2-1:0] ld_addr_i;
    logic [31:0]           ld_data_i;

    modport slave (
        input  req_i, addr_i, ld_we_i, ld_addr_i, ld_data_i,
        output inst_o, ack_o, err_o, busy_o
    );

    modport master (
        output req_i, addr_i, ld_we_i, ld_addr_i, ld_data_i,
        input  inst_o, ack_o, err_o, busy_o
    );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction memory responder with WAIT_STATES wait cycles per fetch and a boot load port.
// Optional misaligned-fetch error: define INST_MEM_ALIGN_CHK_EN.
module inst_mem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst,
    inst_mem_resp_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LAST_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] LAST = LAST_I[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [31:0]           r_addr;
    logic [31:0]           r_inst;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_cap;
    logic                  w_enter_resp;
    logic [31:0]           w_addr;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_oor;
    logic                  w_mis;
    logic                  w_bad;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_i) begin
                    w_cap       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                // A dropped request abandons the fetch; no ack is owed.
                if (!bus.req_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_addr <= '0;
        else if (w_cap) r_addr <= bus.addr_i;
    end

    // ---------------- response datapath ----------------
    // With zero wait states the RESP entry edge is the accept edge, so the
    // live address is used from IDLE; otherwise the captured one.
    assign w_addr       = (r_state == ST_IDLE) ? bus.addr_i : r_addr;
    assign w_idx        = w_addr[DEPTH_LOG2+1:2];
    assign w_oor        = |w_addr[31:DEPTH_LOG2+2];
    assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

`ifdef INST_MEM_ALIGN_CHK_EN
    assign w_mis = |w_addr[1:0];
`else
    logic w_unused_lsb;
    assign w_mis        = 1'b0;
    assign w_unused_lsb = ^w_addr[1:0];
`endif

    assign w_bad = w_oor | w_mis;

    always_ff @(posedge clk) begin
        if (bus.ld_we_i) r_mem[bus.ld_addr_i] <= bus.ld_data_i;
    end

    // r_mem is sampled before the same-edge load lands: read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst <= '0;
            r_err  <= 1'b0;
        end else if (w_enter_resp) begin
            r_err  <= w_bad;
            r_inst <= w_bad ? 32'h0000_0000 : r_mem[w_idx];
        end
    end

    assign bus.inst_o = r_inst;
    assign bus.err_o  = r_err;
    assign bus.ack_o  = (r_state == ST_RESP);
    assign bus.busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_inst_mem_resp.sv
// Randomized self-checking bench for inst_mem_resp against a word-array model.
module tb_inst_mem_resp;
    localparam int DL = 10;
    localparam int WS = 1;
`ifdef INST_MEM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tot, n_bad, cyc, last_ack, last_gap;

    logic [31:0] mm [1 << DL];
    bit          mk [1 << DL];

    inst_mem_resp_if #(.DEPTH_LOG2(DL)) bus ();

    inst_mem_resp #(.DEPTH_LOG2(DL), .WAIT_STATES(WS)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: out of range if any byte-address bit above the array is set.
    task automatic model(input logic [31:0] a, output logic [31:0] ei, output logic ee,
                         output bit known);
        int idx;
        idx   = int'((a >> 2) % (1 << DL));
        ee    = ((a >> (DL + 2)) != 0) || (ALIGN_CHK && (a % 4 != 0));
        ei    = ee ? 32'h0 : mm[idx];
        known = ee || mk[idx];
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = DL'(idx);
        bus.ld_data_i = d;
        @(posedge clk); #1;
        bus.ld_we_i = 1'b0;
        mm[idx] = d;
        mk[idx] = 1'b1;
    endtask

    // Called just after an edge with the FSM idle.
    task automatic fetch(input logic [31:0] a, input bit hold);
        int n;
        logic [31:0] ei;
        logic ee;
        bit known;
        model(a, ei, ee, known);
        bus.req_i  = 1'b1;
        bus.addr_i = a;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!bus.ack_o && n < 20) chk("busy_wait", 32'(bus.busy_o), 32'd1);
        end while (!bus.ack_o && n < 20);
        chk("ack_lat", 32'(n), 32'(WS + 1));
        chk("busy_resp", 32'(bus.busy_o), 32'd1);
        chk("err", 32'(bus.err_o), 32'(ee));
        if (known) chk("inst", bus.inst_o, ei);
        last_gap = cyc - last_ack;
        last_ack = cyc;
        if (!hold) bus.req_i = 1'b0;
        @(posedge clk); #1;
        chk("ack_1cyc", 32'(bus.ack_o), 32'd0);
        chk("busy_idle", 32'(bus.busy_o), 32'd0);
        if (known) chk("inst_hold", bus.inst_o, ei);
    endtask

    task automatic abort_fetch(input logic [31:0] a);
        bus.req_i  = 1'b1;
        bus.addr_i = a;
        @(posedge clk); #1;
        chk("abort_busy", 32'(bus.busy_o), 32'd1);
        bus.req_i = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack", 32'(bus.ack_o), 32'd0);
        chk("abort_idle", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        chk("abort_noack", 32'(bus.ack_o), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int r, idx;
        n_tot = 0; n_bad = 0; cyc = 0; last_ack = 0; last_gap = 0;
        bus.req_i = 1'b0; bus.addr_i = '0;
        bus.ld_we_i = 1'b0; bus.ld_addr_i = '0; bus.ld_data_i = '0;
        for (int i = 0; i < (1 << DL); i++) begin mm[i] = '0; mk[i] = 1'b0; end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_inst", bus.inst_o, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // basic fetch
        load(0, 32'h3C01_1234);
        fetch(32'h0, 1'b0);
        chk("basic_inst", bus.inst_o, 32'h3C01_1234);

        // back-to-back, req held
        load(1, 32'h1111_1111);
        load(2, 32'h2222_2222);
        fetch(32'h4, 1'b1);
        fetch(32'h8, 1'b0);
        chk("b2b_gap", 32'(last_gap), 32'(WS + 2));
        chk("b2b_inst", bus.inst_o, 32'h2222_2222);

        // out of range, then async reset during WAIT
        fetch(32'h0000_1000, 1'b0);
        chk("oor_err", 32'(bus.err_o), 32'd1);
        fetch(32'h0, 1'b0);
        fetch(32'h8000_0004, 1'b0);
        bus.req_i = 1'b1; bus.addr_i = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_ack", 32'(bus.ack_o), 32'd0);
        chk("rstw_err", 32'(bus.err_o), 32'd0);
        chk("rstw_busy", 32'(bus.busy_o), 32'd0);
        chk("rstw_inst", bus.inst_o, 32'h0);
        bus.req_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstw_noack", 32'(bus.ack_o), 32'd0);

        abort_fetch(32'h4);

        // load/read collision on the RESP entry edge
        load(3, 32'hAAAA_AAAA);
        bus.req_i = 1'b1; bus.addr_i = 32'hC;
        repeat (WS) begin @(posedge clk); #1; end
        bus.ld_we_i = 1'b1; bus.ld_addr_i = DL'(3); bus.ld_data_i = 32'hBBBB_BBBB;
        @(posedge clk); #1;
        bus.ld_we_i = 1'b0;
        bus.req_i   = 1'b0;
        chk("coll_ack", 32'(bus.ack_o), 32'd1);
        chk("coll_old", bus.inst_o, 32'hAAAA_AAAA);
        mm[3] = 32'hBBBB_BBBB;
        @(posedge clk); #1;
        fetch(32'hC, 1'b0);
        chk("coll_new", bus.inst_o, 32'hBBBB_BBBB);

        // misaligned
        fetch(32'h6, 1'b0);
        chk("mis_err", 32'(bus.err_o), ALIGN_CHK ? 32'd1 : 32'd0);
        chk("mis_inst", bus.inst_o, ALIGN_CHK ? 32'h0 : 32'h1111_1111);

        // random mix
        for (int i = 0; i < 16; i++) load(i, $urandom);
        for (int it = 0; it < 80; it++) begin
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            if (r <= 2) load(idx, $urandom);
            else if (r <= 6) fetch(32'(idx) << 2, 1'($urandom_range(0, 1)));
            else if (r == 7) fetch((32'(idx) << 2) | 32'($urandom_range(1, 3)), 1'b0);
            else if (r == 8) begin
                a = $urandom;
                a[$urandom_range(DL + 2, 31)] = 1'b1;
                fetch(a, 1'b0);
            end else abort_fetch(32'(idx) << 2);
            bus.req_i = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
